// File: rtl/nano_eint_ctrl_if.sv
// nano_eint_ctrl_if
// Groups the external interrupt lines, the configuration write port and the
// core-side request/acknowledge handshake of the Nano external-interrupt
// controller into one bundle.
//
// Signals
//   eint      external interrupt lines (asynchronous)
//   cfg_we    config write strobe, one cycle
//   cfg_sel   0=MASK(1=masked) 1=EDGE(1=edge) 2=POL(1=rising/high) 3=PEND_CLR(W1C)
//   cfg_data  config write data
//   ack       core accepts the current request (pulse)
//   eoi       core ends service (pulse)
//   irq       request to core
//   irq_id    index of the requested / in-service channel
//   pending   effective pending vector, before masking
//   busy      a request is in service
//   dbg_state controller FSM state (0=IDLE 1=REQ 2=SVC)
//
// Handshake: irq is held high with a stable irq_id until ack is seen while
// irq is high; the request is then in service (busy=1) until eoi is seen.
// ack outside the request phase and eoi outside service are ignored; when
// ack and eoi arrive together in the request phase only ack acts.
//
// Modports
//   master  the side driving lines, config and ack/eoi (core / testbench)
//   slave   the controller itself

interface nano_eint_ctrl_if #(
    parameter int N_INT = 3,
    parameter int ID_W  = 3
);
    logic [N_INT-1:0] eint;
    logic             cfg_we;
    logic [1:0]       cfg_sel;
    logic [N_INT-1:0] cfg_data;
    logic             ack;
    logic             eoi;
    logic             irq;
    logic [ID_W-1:0]  irq_id;
    logic [N_INT-1:0] pending;
    logic             busy;
    logic [1:0]       dbg_state;

    modport master (
        output eint, cfg_we, cfg_sel, cfg_data, ack, eoi,
        input  irq, irq_id, pending, busy, dbg_state
    );

    modport slave (
        input  eint, cfg_we, cfg_sel, cfg_data, ack, eoi,
        output irq, irq_id, pending, busy, dbg_state
    );
endinterface

// File: rtl/nano_eint_ctrl.sv
// nano_eint_ctrl
// Parametrised external-interrupt controller. Each channel passes through a
// synchroniser, is normalised to an active-high view by its polarity bit and
// is either followed directly (level mode) or latched as pending on a rising
// event (edge mode). A fixed-priority arbiter (channel 0 highest) presents
// one request at a time to the core, which takes it with ack and retires it
// with eoi. No nesting: events arriving during service only pend.
//
// Ports
//   clk   system clock
//   rst   synchronous reset, active-high
//   bus   nano_eint_ctrl_if.slave (lines, config, ack/eoi, irq/irq_id,
//         pending, busy, dbg_state)
//
// Parameters
//   N_INT        number of channels (1..8)
//   SYNC_STAGES  synchroniser depth (>=2)
//   ID_W         width of irq_id, 2**ID_W >= N_INT

module nano_eint_ctrl #(
    parameter int N_INT       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = 3
) (
    input  logic               clk,
    input  logic               rst,
    nano_eint_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [N_INT-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= bus.eint;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    logic [N_INT-1:0] mask_q, edge_q, pol_q;
    logic [N_INT-1:0] mask_d, edge_d, pol_d;
    logic             wr_mask, wr_edge, wr_pol, wr_pclr;

    assign wr_mask = bus.cfg_we && (bus.cfg_sel == 2'd0);
    assign wr_edge = bus.cfg_we && (bus.cfg_sel == 2'd1);
    assign wr_pol  = bus.cfg_we && (bus.cfg_sel == 2'd2);
    assign wr_pclr = bus.cfg_we && (bus.cfg_sel == 2'd3);

    assign mask_d = wr_mask ? bus.cfg_data : mask_q;
    assign edge_d = wr_edge ? bus.cfg_data : edge_q;
    assign pol_d  = wr_pol  ? bus.cfg_data : pol_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '1;
            edge_q <= '1;
            pol_q  <= '1;
        end else begin
            mask_q <= mask_d;
            edge_q <= edge_d;
            pol_q  <= pol_d;
        end
    end

    // ------------------------------------------------------------------
    // Active-high view and event detection
    // ------------------------------------------------------------------
    logic [N_INT-1:0] s_now;
    logic [N_INT-1:0] s_prev_q;
    logic [N_INT-1:0] s_prev_d;
    logic [N_INT-1:0] evt;

    assign s_now = sync_q[SYNC_STAGES-1] ^ ~pol_q;

    // s_prev is always reloaded through the polarity that will be in force
    // next cycle. Outside a POL write this equals s_now; on a POL write it
    // keeps the flipped view from looking like a fresh rising event.
    assign s_prev_d = sync_q[SYNC_STAGES-1] ^ ~pol_d;
    assign evt      = s_now & ~s_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_prev_q <= '0;
        end else begin
            s_prev_q <= s_prev_d;
        end
    end

    // ------------------------------------------------------------------
    // Pending latch (edge channels only)
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;
    logic [N_INT-1:0] pend_q, pend_d;
    logic [N_INT-1:0] pend_clr, ack_clr;
    logic [N_INT-1:0] pend_eff, req_vec;
    logic             ack_take;

    assign ack_take = (state_q == ST_REQ) && bus.ack;
    assign pend_clr = wr_pclr ? bus.cfg_data : '0;

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < N_INT; i++) begin
            ack_clr[i] = ack_take && (irq_id_q == ID_W'(i));
        end
    end

    // Clears are applied first and the event is OR-ed after, so a set and a
    // clear in the same cycle leave the bit set. Bits of level channels are
    // held at zero so a later switch to edge mode starts clean.
    assign pend_d = ((pend_q & ~(pend_clr | ack_clr)) | evt) & edge_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_eff = (edge_q & pend_q) | (~edge_q & s_now);
    assign req_vec  = pend_eff & ~mask_q;

    // ------------------------------------------------------------------
    // Fixed-priority pick: lowest set index wins
    // ------------------------------------------------------------------
    logic [ID_W-1:0] lowest_id;

    always_comb begin
        lowest_id = '0;
        for (int i = N_INT - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                lowest_id = ID_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Request / service FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            irq_id_q <= '0;
        end else begin
            state_q  <= state_d;
            irq_id_q <= irq_id_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_vec) begin
                    state_d  = ST_REQ;
                    irq_id_d = lowest_id;
                end
            end
            ST_REQ: begin
                // eoi is deliberately not looked at here
                if (bus.ack) begin
                    state_d = ST_SVC;
                end
            end
            ST_SVC: begin
                if (bus.eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode the registered state, so they are glitch-free.
    assign bus.irq       = (state_q == ST_REQ);
    assign bus.busy      = (state_q == ST_SVC);
    assign bus.irq_id    = irq_id_q;
    assign bus.pending   = pend_eff;
    assign bus.dbg_state = state_q;

endmodule
